// File: rtl/snake_pkg.sv
// Shared direction type and screen constants for the snake game datapath.
package snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int CELL     = 10;

  // Opposite pairs differ only in bit 0 (UP/DOWN, LEFT/RIGHT).
  function automatic dir_t dir_reverse(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/step_timer.sv
// Game step timer: tick_cnt runs 0..TICKS-1 while enabled, holds while disabled.
module step_timer #(
  parameter int TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tc
);

  localparam int              W    = $clog2(TICKS);
  localparam logic [W-1:0]    LAST = W'(TICKS - 1);

  logic [W-1:0] tick_cnt;

  assign tc = en && (tick_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (en) begin
      tick_cnt <= (tick_cnt == LAST) ? '0 : tick_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/snake_head_stepper.sv
// Snake head position stepper: direction latch plus per-step head move.
// Build option SNAKE_WALL_WRAP_EN: playfield edges wrap instead of raising wall_hit.
module snake_head_stepper
  import snake_pkg::*;
#(
  parameter int TICKS_PER_STEP = 2500000,
  parameter int STEP           = CELL,
  parameter int X_MAX          = SCREEN_W,
  parameter int Y_MAX          = SCREEN_H,
  parameter int X_INIT         = 320,
  parameter int Y_INIT         = 240
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       move_en,
  input  logic [3:0] dir_btn,
  output logic [9:0] head_x,
  output logic [9:0] head_y,
  output dir_t       dir_cur,
  output logic       step_pulse,
  output logic       wall_hit
);

  localparam logic [9:0] STEP10 = 10'(STEP);
  localparam logic [9:0] X_LIM  = 10'(X_MAX - STEP);
  localparam logic [9:0] Y_LIM  = 10'(Y_MAX - STEP);
  localparam logic [9:0] X_RST  = 10'(X_INIT);
  localparam logic [9:0] Y_RST  = 10'(Y_INIT);

  logic       tick_done;
  logic       step_ev;
  logic       req_valid;
  logic       blocked;
  dir_t       req_dir;
  dir_t       dir_pend;
  dir_t       pend_next;
  logic [9:0] cand_x;
  logic [9:0] cand_y;

  step_timer #(.TICKS(TICKS_PER_STEP)) u_step_timer (
    .clk (clk),
    .rst (rst),
    .en  (move_en),
    .tc  (tick_done)
  );

  assign step_ev = tick_done && !wall_hit;

  always_comb begin
    req_valid = 1'b1;
    req_dir   = RIGHT;
    pend_next = dir_pend;
    if (dir_btn[3])      req_dir = UP;
    else if (dir_btn[2]) req_dir = DOWN;
    else if (dir_btn[1]) req_dir = LEFT;
    else if (dir_btn[0]) req_dir = RIGHT;
    else                 req_valid = 1'b0;
    if (req_valid && (req_dir != dir_reverse(dir_cur))) pend_next = req_dir;
  end

  // Decrement below 0 wraps modulo 1024, so one "> limit" test covers both edges.
  always_comb begin
    cand_x = head_x;
    cand_y = head_y;
    case (dir_pend)
      UP:    cand_y = head_y - STEP10;
      DOWN:  cand_y = head_y + STEP10;
      LEFT:  cand_x = head_x - STEP10;
      RIGHT: cand_x = head_x + STEP10;
    endcase
`ifdef SNAKE_WALL_WRAP_EN
    if (cand_x > X_LIM) cand_x = (dir_pend == LEFT) ? X_LIM : '0;
    if (cand_y > Y_LIM) cand_y = (dir_pend == UP)   ? Y_LIM : '0;
    blocked = 1'b0;
`else
    blocked = (cand_x > X_LIM) || (cand_y > Y_LIM);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_x     <= X_RST;
      head_y     <= Y_RST;
      dir_cur    <= RIGHT;
      dir_pend   <= RIGHT;
      step_pulse <= 1'b0;
    end else begin
      dir_pend   <= pend_next;
      step_pulse <= 1'b0;
      if (step_ev && !blocked) begin
        head_x     <= cand_x;
        head_y     <= cand_y;
        dir_cur    <= dir_pend;
        step_pulse <= 1'b1;
      end
    end
  end

`ifdef SNAKE_WALL_WRAP_EN
  assign wall_hit = 1'b0;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wall_hit <= 1'b0;
    end else if (step_ev && blocked) begin
      wall_hit <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_snake_head_stepper.sv
// Self-checking bench for snake_head_stepper with a 4-tick step and 640x480 field.
module tb_snake_head_stepper;
  import snake_pkg::*;

  localparam int TPS = 4;
  localparam int ST  = 10;
  localparam int XM  = 640;
  localparam int YM  = 480;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       move_en = 1'b0;
  logic [3:0] dir_btn = 4'b0000;
  logic [9:0] head_x;
  logic [9:0] head_y;
  dir_t       dir_cur;
  logic       step_pulse;
  logic       wall_hit;

  int total = 0;
  int bad   = 0;

  snake_head_stepper #(
    .TICKS_PER_STEP(TPS), .STEP(ST), .X_MAX(XM), .Y_MAX(YM), .X_INIT(320), .Y_INIT(240)
  ) dut (
    .clk(clk), .rst(rst), .move_en(move_en), .dir_btn(dir_btn),
    .head_x(head_x), .head_y(head_y), .dir_cur(dir_cur),
    .step_pulse(step_pulse), .wall_hit(wall_hit)
  );

  always #5 clk = ~clk;

  // Reference model: position in plain integers, directions as 0=up 1=down 2=left 3=right.
  int m_x, m_y, m_dir, m_pend, m_phase, m_pulse, m_wall;
  int dx [4] = '{0, 0, -ST, ST};
  int dy [4] = '{-ST, ST, 0, 0};
  int opp[4] = '{1, 0, 3, 2};

  always @(posedge clk or posedge rst) begin
    int req, nx, ny, new_pend;
    bit ev, off;
    if (rst) begin
      m_x = 320; m_y = 240; m_dir = 3; m_pend = 3;
      m_phase = 0; m_pulse = 0; m_wall = 0;
    end else begin
      req = -1;
      for (int b = 3; b >= 0; b--) if (dir_btn[b] && req < 0) req = 3 - b;
      new_pend = (req >= 0 && req != opp[m_dir]) ? req : m_pend;
      ev = move_en && (m_wall == 0) && (m_phase == TPS - 1);
      if (move_en) m_phase = (m_phase + 1) % TPS;
      m_pulse = 0;
      if (ev) begin
        nx = m_x + dx[m_pend];
        ny = m_y + dy[m_pend];
        off = (nx < 0) || (nx > XM - ST) || (ny < 0) || (ny > YM - ST);
`ifdef SNAKE_WALL_WRAP_EN
        nx = (nx + XM) % XM;
        ny = (ny + YM) % YM;
        off = 0;
`endif
        if (off) m_wall = 1;
        else begin
          m_x = nx; m_y = ny; m_dir = m_pend; m_pulse = 1;
        end
      end
      m_pend = new_pend;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_head_x", 32'(head_x), 32'(m_x));
    check("model_head_y", 32'(head_y), 32'(m_y));
    check("model_dir_cur", 32'(dir_cur), 32'(m_dir));
    check("model_step_pulse", 32'(step_pulse), 32'(m_pulse));
    check("model_wall_hit", 32'(wall_hit), 32'(m_wall));
  end

  task automatic wait_pulse(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!step_pulse && cyc < 40);
    if (!step_pulse) begin
      total++; bad++;
      $display("FAIL pulse_timeout actual=no_pulse expected=pulse at %0t", $time);
    end
  endtask

  task automatic tap(input logic [3:0] b);
    dir_btn = b;
    @(negedge clk);
    dir_btn = 4'b0000;
  endtask

  initial begin
    int cyc, npulse;
    repeat (3) @(negedge clk);
    check("rst_head_x", 32'(head_x), 320);
    check("rst_head_y", 32'(head_y), 240);
    check("rst_dir", 32'(dir_cur), 3);
    check("rst_pulse", 32'(step_pulse), 0);
    check("rst_wall", 32'(wall_hit), 0);

    rst = 1'b0; move_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wait_pulse(cyc);
      check("step_period", cyc, 4);
      check("step_x", 32'(head_x), 32'(320 + 10 * i));
      check("step_y", 32'(head_y), 240);
    end

    tap(4'b1000);
    wait_pulse(cyc);
    check("up_y", 32'(head_y), 230);
    check("up_x", 32'(head_x), 350);
    check("up_dir", 32'(dir_cur), 0);

    tap(4'b0001);
    wait_pulse(cyc);
    check("right_x", 32'(head_x), 360);
    tap(4'b0010);
    wait_pulse(cyc);
    check("rev_ignored_x", 32'(head_x), 370);
    check("rev_ignored_dir", 32'(dir_cur), 3);

    repeat (2) @(negedge clk);
    move_en = 1'b0;
    npulse = 0;
    repeat (10) begin
      @(negedge clk);
      if (step_pulse) npulse++;
    end
    check("hold_no_pulse", npulse, 0);
    move_en = 1'b1;
    wait_pulse(cyc);
    check("hold_resume_cycles", cyc, 2);
    check("hold_resume_x", 32'(head_x), 380);

    for (int i = 0; i < 40 && head_x != 10'd630; i++) wait_pulse(cyc);
    check("edge_x", 32'(head_x), 630);
`ifdef SNAKE_WALL_WRAP_EN
    wait_pulse(cyc);
    check("wrap_x", 32'(head_x), 0);
    tap(4'b1000);
    for (int i = 0; i < 40 && head_y != 10'd0; i++) wait_pulse(cyc);
    check("top_y", 32'(head_y), 0);
    wait_pulse(cyc);
    check("wrap_y", 32'(head_y), 470);
    check("wrap_wall", 32'(wall_hit), 0);
`else
    repeat (4) @(negedge clk);
    check("wall_set", 32'(wall_hit), 1);
    check("wall_pulse", 32'(step_pulse), 0);
    check("wall_x", 32'(head_x), 630);
    npulse = 0;
    repeat (12) begin
      @(negedge clk);
      if (step_pulse) npulse++;
    end
    check("wall_frozen", npulse, 0);
    check("wall_frozen_x", 32'(head_x), 630);
`endif

    dir_btn = 4'b1010;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_rst_x", 32'(head_x), 320);
    check("async_rst_y", 32'(head_y), 240);
    check("async_rst_dir", 32'(dir_cur), 3);
    check("async_rst_wall", 32'(wall_hit), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_pulse(cyc);
    check("post_rst_cycles", cyc, 4);
    check("post_rst_y", 32'(head_y), 230);
    check("post_rst_x", 32'(head_x), 320);
    check("post_rst_dir", 32'(dir_cur), 0);
    dir_btn = 4'b0000;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
